// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider.
package clk_div_pkg;

    localparam int unsigned NUM_CH_DEF = 2;
    localparam int unsigned CNT_W_DEF  = 16;
    localparam int unsigned CH_W       = (NUM_CH_DEF > 1) ? $clog2(NUM_CH_DEF) : 1;

    typedef logic [CNT_W_DEF-1:0] div_t;

    // Divisor value that parks a channel.
    localparam int unsigned DIV_STOP = 0;
    // Smallest divisor that produces a running clock.
    localparam int unsigned DIV_MIN  = 2;

    // Channel-select width for a given channel count (never below 1 bit).
    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, live divisor, shadow divisor, pending flag,
// registered div_clk and tick. Optional phase alignment via sync_start when
// CLK_DIV_SYNC_EN is defined.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned DEF_DIV = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
`ifdef CLK_DIV_SYNC_EN
    input  logic             sync_start,
`endif
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_div,
    output logic             pending,
    output logic             div_clk,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             div_clk_q, div_clk_d;
    logic             tick_q, tick_d;
    logic             boundary;

    // Counter, outputs and divisor apply; a fresh write wins over an apply.
    always_comb begin
        cnt_d     = cnt_q;
        div_d     = div_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        div_clk_d = 1'b0;
        tick_d    = 1'b0;
        boundary  = 1'b0;

        if (!en || (div_q == CNT_W'(DIV_STOP))) begin
            cnt_d    = '0;
            boundary = 1'b1;
        end else begin
            div_clk_d = (cnt_q < (div_q >> 1));
            tick_d    = (cnt_q == '0);
            if (cnt_q == (div_q - CNT_W'(1))) begin
                cnt_d    = '0;
                boundary = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

`ifdef CLK_DIV_SYNC_EN
        if (sync_start && en) begin
            cnt_d    = '0;
            boundary = 1'b1;
        end
`endif

        if (wr_en) begin
            shadow_d  = (wr_div == CNT_W'(1)) ? CNT_W'(DIV_MIN) : wr_div;
            pending_d = 1'b1;
        end else if (boundary && pending_q) begin
            div_d     = shadow_q;
            pending_d = 1'b0;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            div_q     <= CNT_W'(DEF_DIV);
            shadow_q  <= '0;
            pending_q <= 1'b0;
            div_clk_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            div_clk_q <= div_clk_d;
            tick_q    <= tick_d;
        end
    end

    assign pending = pending_q;
    assign div_clk = div_clk_q;
    assign tick    = tick_q;

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel programmable integer clock divider with a valid/ready
// divisor write port. Define CLK_DIV_SYNC_EN to add the sync_start input
// that re-phases all enabled channels together.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned DEF_DIV = 11
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CH-1:0]             ch_en,
`ifdef CLK_DIV_SYNC_EN
    input  logic                          sync_start,
`endif
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [ch_width(NUM_CH)-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]              cfg_div,
    output logic [NUM_CH-1:0]             div_clk,
    output logic [NUM_CH-1:0]             tick
);

    localparam int unsigned SEL_W = ch_width(NUM_CH);

    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] wr_en;

    // Channel decode and ready mux; out-of-range selects never match.
    always_comb begin
        cfg_ready = 1'b0;
        wr_en     = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == SEL_W'(i)) begin
                cfg_ready = !pend[i];
                wr_en[i]  = cfg_valid && !pend[i];
            end
        end
    end

    // One divider instance per channel.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_chan #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (ch_en[g]),
`ifdef CLK_DIV_SYNC_EN
            .sync_start (sync_start),
`endif
            .wr_en      (wr_en[g]),
            .wr_div     (cfg_div),
            .pending    (pend[g]),
            .div_clk    (div_clk[g]),
            .tick       (tick[g])
        );
    end

endmodule
